ascon_enc_feeder: RTL and testbench

ASCON_ENC_FEEDER -- requirements
Module: ascon_enc_feeder

---
 rtl/ascon_pkg.sv | 35 +++
 rtl/ascon_enc_feeder.sv | 139 +++++++++++++
 tb/tb_ascon_enc_feeder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON encryption feeder: word width, FSM states
// and the word-count helpers derived from the field widths.
package ascon_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT,
    ACK,
    DRAIN
  } state_t;

  function automatic int num_k(input int k);
    return k / WORD_W;
  endfunction

  function automatic int num_a(input int l);
    return (l + WORD_W - 1) / WORD_W;
  endfunction

  function automatic int num_y(input int y);
    return (y + WORD_W - 1) / WORD_W;
  endfunction

  function automatic int num_in(input int k, input int l, input int y);
    return num_k(k) + 4 + num_a(l) + num_y(y);
  endfunction

  function automatic int num_out(input int y);
    return num_y(y) + 4;
  endfunction

endpackage

// File: rtl/ascon_enc_feeder.sv
// Gathers key/nonce/AD/PT from a 32-bit word stream, hands them to an external
// ASCON engine, then streams cipher text and tag back out as 32-bit words.
//
// state | meaning
// LOAD  | accepting input words into the field registers
// START | one-cycle enc_start strobe launching the engine
// WAIT  | waiting for enc_ready; results captured on it
// ACK   | one-cycle enc_start strobe returning the engine to idle
// DRAIN | presenting cipher words then tag words on the output stream
module ascon_enc_feeder
  import ascon_pkg::*;
#(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic [K-1:0]  key,
  output logic [127:0]  nonce,
  output logic [L-1:0]  associated_data,
  output logic [Y-1:0]  plain_text,
  output logic          enc_start,
  input  logic          enc_ready,
  input  logic [Y-1:0]  cipher_text,
  input  logic [127:0]  tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int NK   = num_k(K);
  localparam int NA   = num_a(L);
  localparam int NY   = num_y(Y);
  localparam int NIN  = num_in(K, L, Y);
  localparam int NOUT = num_out(Y);
  localparam int PW   = NY * WORD_W;
  localparam int ICW  = $clog2(NIN);
  localparam int OCW  = $clog2(NOUT);

  localparam logic [ICW-1:0] IN_LAST  = ICW'(NIN - 1);
  localparam logic [ICW-1:0] B_NONCE  = ICW'(NK);
  localparam logic [ICW-1:0] B_AD     = ICW'(NK + 4);
  localparam logic [ICW-1:0] B_PT     = ICW'(NK + 4 + NA);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(NOUT - 1);

  state_t           state, state_nxt;
  logic [ICW-1:0]   in_idx;
  logic [OCW-1:0]   out_idx;
  logic [K-1:0]     key_q;
  logic [127:0]     nonce_q;
  logic [L-1:0]     ad_q;
  logic [Y-1:0]     pt_q;
  logic [Y-1:0]     ct_q;
  logic [127:0]     tag_q;
  logic             in_xfer, in_done, out_xfer, out_done;

  logic [NOUT*WORD_W-1:0] res_all;
  logic [WORD_W-1:0]      words [NOUT];

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign out_valid = (state == DRAIN);
  assign in_xfer   = in_valid && in_ready;
  assign in_done   = in_xfer && (in_idx == IN_LAST);
  assign out_xfer  = out_valid && out_ready;
  assign out_done  = out_xfer && (out_idx == OUT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_done) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (enc_ready) state_nxt = ACK;
      ACK:     state_nxt = DRAIN;
      DRAIN:   if (out_done) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      enc_start <= 1'b0;
      in_idx    <= '0;
      out_idx   <= '0;
    end else begin
      state     <= state_nxt;
      // Registered strobe: high for exactly the START and ACK cycles.
      enc_start <= (state_nxt == START) || (state_nxt == ACK);
      if (in_xfer) in_idx <= in_done ? '0 : in_idx + ICW'(1);
      if (out_xfer) out_idx <= out_done ? '0 : out_idx + OCW'(1);
    end
  end

  // Field registers keep only their low bits, so a shift-in discards the top word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      pt_q    <= '0;
    end else if (in_xfer) begin
      if (in_idx < B_NONCE)   key_q   <= K'({key_q, in_data});
      else if (in_idx < B_AD) nonce_q <= {nonce_q[95:0], in_data};
      else if (in_idx < B_PT) ad_q    <= L'({ad_q, in_data});
      else                    pt_q    <= Y'({pt_q, in_data});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_q  <= '0;
      tag_q <= '0;
    end else if (state == WAIT && enc_ready) begin
      ct_q  <= cipher_text;
      tag_q <= tag;
    end
  end

  assign res_all = {PW'(ct_q), tag_q};

  for (genvar j = 0; j < NOUT; j++) begin : g_word
    assign words[j] = res_all[(NOUT-1-j)*WORD_W +: WORD_W];
  end

  assign out_data        = words[out_idx];
  assign out_last        = (state == DRAIN) && (out_idx == OUT_LAST);
  assign key             = key_q;
  assign nonce           = nonce_q;
  assign associated_data = ad_q;
  assign plain_text      = pt_q;

endmodule

// File: tb/tb_ascon_enc_feeder.sv
// Scoreboard bench for ascon_enc_feeder: loads directed vectors, a stub engine
// answers each start, and a monitor checks the drained word stream.
module tb_ascon_enc_feeder;

  localparam int K = 128;
  localparam int L = 40;
  localparam int Y = 40;

  localparam logic [127:0] EXP_KEY  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [39:0]  EXP_AD   = 40'h0001020304;
  localparam logic [39:0]  EXP_PT   = 40'hAABBCCDDEE;
  localparam logic [39:0]  CT_BASE  = 40'hA1B2C3D4E5;
  localparam logic [127:0] TAG_BASE = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [K-1:0] key;
  logic [127:0] nonce;
  logic [L-1:0] associated_data;
  logic [Y-1:0] plain_text;
  logic         enc_start;
  logic         enc_ready = 1'b0;
  logic [Y-1:0] cipher_text = '0;
  logic [127:0] tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;

  ascon_enc_feeder #(.K(K), .L(L), .Y(Y)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key(key), .nonce(nonce), .associated_data(associated_data), .plain_text(plain_text),
    .enc_start(enc_start), .enc_ready(enc_ready), .cipher_text(cipher_text), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        q[$];
  logic [31:0] vec [12] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                            32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                            32'h00000000, 32'h01020304, 32'h000000AA, 32'hBBCCDDEE};
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tx_issued = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int stall_left = 0;
  int mon_idx = 0;
  bit stub_busy = 1'b0;
  logic [31:0] hold_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_expected(input int t);
    logic [63:0]  ext;
    logic [127:0] tg;
    ext = {24'h0, CT_BASE + 40'(t)};
    tg  = TAG_BASE + 128'(t);
    q.push_back('{ext[63:32], 1'b0});
    q.push_back('{ext[31:0], 1'b0});
    q.push_back('{tg[127:96], 1'b0});
    q.push_back('{tg[95:64], 1'b0});
    q.push_back('{tg[63:32], 1'b0});
    q.push_back('{tg[31:0], 1'b1});
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 1000 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_tx(input bit gaps);
    push_expected(tx_issued);
    tx_issued++;
    for (int i = 0; i < 12; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(vec[i]);
      if (i == 6) check("busy_during_load", 128'(busy), 128'(0));
    end
    check("start_latency", 128'(enc_start), 128'(1));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q.size() != 0 || stub_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", q.size());
    end
    check("drain_count", 128'(done_cnt), 128'(tx_issued));
  endtask

  // Output monitor: owns out_ready, pops the scoreboard on every transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (stall_left > 0 && mon_idx == 2) begin
          if (stall_left == 5) hold_d = out_data;
          else begin
            check("stall_hold_data", 128'(out_data), 128'(hold_d));
            check("stall_hold_last", 128'(out_last), 128'(0));
          end
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got word %h expected no output", out_data);
          end else begin
            e = q.pop_front();
            check("out_data", 128'(out_data), 128'(e.d));
            check("out_last", 128'(out_last), 128'(e.l));
            mon_idx = e.l ? 0 : mon_idx + 1;
            if (e.l) done_cnt++;
          end
        end
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Stub engine: answers 20 cycles after each start, expects one ACK strobe.
  initial begin
    int t;
    forever begin
      @(negedge clk);
      if (enc_start) begin
        stub_busy = 1'b1;
        check("start_after_prev_last", 128'(done_cnt), 128'(start_cnt));
        t = start_cnt;
        start_cnt++;
        check("key", key, EXP_KEY);
        check("nonce", nonce, EXP_KEY);
        check("associated_data", 128'(associated_data), 128'(EXP_AD));
        check("plain_text", 128'(plain_text), 128'(EXP_PT));
        repeat (20) @(negedge clk);
        check("wait_no_start", 128'(enc_start), 128'(0));
        cipher_text = CT_BASE + 40'(t);
        tag         = TAG_BASE + 128'(t);
        enc_ready   = 1'b1;
        @(negedge clk);
        enc_ready   = 1'b0;
        cipher_text = 40'h5A5A5A5A5A;
        tag         = {4{32'hDEADBEEF}};
        check("ack_pulse", 128'(enc_start), 128'(1));
        @(negedge clk);
        check("ack_end", 128'(enc_start), 128'(0));
        stub_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_last", 128'(out_last), 128'(0));
    check("rst_enc_start", 128'(enc_start), 128'(0));
    check("rst_key", key, 128'(0));

    load_tx(1'b0);
    wait_done();

    stall_left = 5;
    load_tx(1'b1);
    wait_done();
    check("stall_consumed", 128'(stall_left), 128'(0));

    // Partial load, stray enc_ready in LOAD, then reset mid-load.
    for (int i = 0; i < 7; i++) begin
      send_word(32'hDEAD0000 + 32'(i));
      if (i == 3) begin
        cipher_text = 40'h1122334455;
        enc_ready   = 1'b1;
        @(negedge clk);
        enc_ready   = 1'b0;
        check("stray_ready_in_ready", 128'(in_ready), 128'(1));
        check("stray_ready_busy", 128'(busy), 128'(0));
        check("stray_ready_start", 128'(enc_start), 128'(0));
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midload_rst_key", key, 128'(0));
    check("midload_rst_nonce", nonce, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 128'(busy), 128'(0));

    load_tx(1'b1);
    @(negedge clk);
    in_data  = 32'hFFFFFFFF;
    in_valid = 1'b1;
    repeat (10) begin
      check("wait_in_ready", 128'(in_ready), 128'(0));
      check("wait_busy", 128'(busy), 128'(1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("wait_key_held", key, EXP_KEY);
    check("wait_pt_held", 128'(plain_text), 128'(EXP_PT));
    wait_done();

    load_tx(1'b0);
    load_tx(1'b1);
    wait_done();
    check("start_total", 128'(start_cnt), 128'(5));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
